// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// over operand magnitudes, one bit per cycle, with a sign fix-up on the final edge.
module mdu_iterative #(
  parameter int BW    = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [BW-1:0] d1,
  input  logic [BW-1:0] d2,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_REM = 3'b110;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             s1_neg;
  logic             s2_neg;
  logic [BW-1:0]    b_mag;  // multiplicand for multiply, divisor for divide
  logic [BW-1:0]    acc;    // product high half / partial remainder
  logic [BW-1:0]    lo;     // multiplier shifting out / dividend shifting into quotient

  // Operand decode for the request being offered in IDLE.
  logic          d1_signed, d2_signed;
  logic          d1_neg, d2_neg;
  logic [BW-1:0] d1_mag, d2_mag;
  logic          div_by_zero, div_overflow;
  logic [BW-1:0] special_res;

  assign d1_signed = (op == 3'b001) || (op == 3'b010) || (op == OP_DIV) || (op == OP_REM);
  assign d2_signed = (op == 3'b001) || (op == OP_DIV) || (op == OP_REM);
  assign d1_neg    = d1_signed & d1[BW-1];
  assign d2_neg    = d2_signed & d2[BW-1];
  assign d1_mag    = d1_neg ? (~d1 + 1'b1) : d1;
  assign d2_mag    = d2_neg ? (~d2 + 1'b1) : d2;

  assign div_by_zero  = op[2] && (d2 == '0);
  assign div_overflow = ((op == OP_DIV) || (op == OP_REM)) &&
                        (d1 == {1'b1, {(BW-1){1'b0}}}) && (d2 == '1);
  // Overflow returns d1 (the most negative value) for DIV and zero for REM.
  assign special_res  = div_by_zero ? (op[1] ? d1 : '1) : (op[1] ? '0 : d1);

  // One multiply step: conditional add into the upper half, then shift right.
  logic [BW:0]   mul_sum;
  logic [BW-1:0] mul_acc_nx, mul_lo_nx;

  assign mul_sum    = {1'b0, acc} + (lo[0] ? {1'b0, b_mag} : {(BW+1){1'b0}});
  assign mul_acc_nx = mul_sum[BW:1];
  assign mul_lo_nx  = {mul_sum[0], lo[BW-1:1]};

  // One restoring divide step; the shifted remainder keeps its carry bit so
  // divisors above 2^(BW-1) still compare correctly.
  logic [BW:0]   rem_sh;
  logic          rem_ge;
  logic [BW-1:0] rem_sub;
  logic [BW-1:0] div_acc_nx, div_lo_nx;

  assign rem_sh     = {acc, lo[BW-1]};
  assign rem_ge     = rem_sh >= {1'b0, b_mag};
  assign rem_sub    = rem_sh[BW-1:0] - b_mag;
  assign div_acc_nx = rem_ge ? rem_sub : rem_sh[BW-1:0];
  assign div_lo_nx  = {lo[BW-2:0], rem_ge};

  logic [BW-1:0] acc_nx, lo_nx;
  assign acc_nx = op_q[2] ? div_acc_nx : mul_acc_nx;
  assign lo_nx  = op_q[2] ? div_lo_nx  : mul_lo_nx;

  // Sign fix-up applied to the values produced by the last iteration.
  logic [2*BW-1:0] prod, prod_s;
  logic [BW-1:0]   quot_s, rem_s, final_res;

  assign prod   = {acc_nx, lo_nx};
  assign prod_s = (s1_neg ^ s2_neg) ? (~prod + 1'b1) : prod;
  assign quot_s = (s1_neg ^ s2_neg) ? (~lo_nx + 1'b1) : lo_nx;
  assign rem_s  = s1_neg ? (~acc_nx + 1'b1) : acc_nx;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves the output
    // unassigned, which would otherwise infer a latch.
    final_res = rem_s;
    case (op_q)
      OP_MUL:                   final_res = prod_s[BW-1:0];
      3'b001, 3'b010, 3'b011:   final_res = prod_s[2*BW-1:BW];
      OP_DIV, 3'b101:           final_res = quot_s;
      default:                  final_res = rem_s;
    endcase
  end

  assign busy = (state != S_IDLE);

  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from the pre-edge values, avoiding simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      res    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      s1_neg <= 1'b0;
      s2_neg <= 1'b0;
      b_mag  <= '0;
      acc    <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_q   <= op;
            s1_neg <= d1_neg;
            s2_neg <= d2_neg;
            b_mag  <= d2_mag;
            acc    <= '0;
            lo     <= d1_mag;
            cnt    <= '0;
            if (div_by_zero || div_overflow) begin
              state <= S_DONE;
              done  <= 1'b1;
              res   <= special_res;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_nx;
            lo  <= lo_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(BW - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
              res   <= final_res;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
